// File: rtl/vga_timing_gen.sv
// Raster timing for a 640x480@60 style display: pixel/line counters, sync, blank and frame strobes.
// Every output is registered from next-state values, so all of them line up with DrawX/DrawY.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_FRONT_AT = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_AT  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BACK_AT  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_FRONT_AT = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_AT  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BACK_AT  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {StDisp, StFront, StSync, StBack} phase_e;

  phase_e      h_state_q, h_state_d, v_state_q, v_state_d;
  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic        h_wrap;
  logic        line_start_d, frame_start_d;
  logic [15:0] frame_count_d;

  logic        hs_q, vs_q, blank_q, line_start_q, frame_start_q;
  logic [9:0]  draw_x_q, draw_y_q;
  logic [15:0] frame_count_q;

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;

    h_state_d = h_state_q;
    unique case (h_state_q)
      StDisp:  if (h_cnt_d == H_FRONT_AT) h_state_d = StFront;
      StFront: if (h_cnt_d == H_SYNC_AT)  h_state_d = StSync;
      StSync:  if (h_cnt_d == H_BACK_AT)  h_state_d = StBack;
      StBack:  if (h_cnt_d == 10'd0)      h_state_d = StDisp;
    endcase

    // Vertical phase only moves on the horizontal wrap.
    v_state_d = v_state_q;
    if (h_wrap) begin
      unique case (v_state_q)
        StDisp:  if (v_cnt_d == V_FRONT_AT) v_state_d = StFront;
        StFront: if (v_cnt_d == V_SYNC_AT)  v_state_d = StSync;
        StSync:  if (v_cnt_d == V_BACK_AT)  v_state_d = StBack;
        StBack:  if (v_cnt_d == 10'd0)      v_state_d = StDisp;
      endcase
    end

    line_start_d  = (h_cnt_d == 10'd0);
    frame_start_d = line_start_d && (v_cnt_d == 10'd0);
    frame_count_d = frame_start_d ? frame_count_q + 16'd1 : frame_count_q;
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      h_cnt_q       <= H_LAST;
      v_cnt_q       <= V_LAST;
      h_state_q     <= StBack;
      v_state_q     <= StBack;
      draw_x_q      <= '0;
      draw_y_q      <= '0;
      blank_q       <= 1'b0;
      hs_q          <= ~SYNC_ACTIVE;
      vs_q          <= ~SYNC_ACTIVE;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      draw_x_q      <= h_cnt_d;
      draw_y_q      <= v_cnt_d;
      blank_q       <= (h_state_d == StDisp) && (v_state_d == StDisp);
      hs_q          <= (h_state_d == StSync) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vs_q          <= (v_state_d == StSync) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign DrawX       = draw_x_q;
  assign DrawY       = draw_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a shrunken-timing instance (16x13 raster) for frame-level checks and a
// default 800x525 instance for one-line pixel-exact checks.
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;

  logic        hs, vs, blank, line_start, frame_start;
  logic [9:0]  DrawX, DrawY;
  logic [15:0] frame_count;

  logic        d_hs, d_vs, d_blank, d_line_start, d_frame_start;
  logic [9:0]  d_DrawX, d_DrawY;
  logic [15:0] d_frame_count;

  int tests = 0;
  int fails = 0;

  always #5 vga_clk = ~vga_clk;

  // Small raster: H 8+2+3+3=16 (hs low at X 10..12), V 6+2+2+3=13 (vs low on lines 8..9).
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_ACTIVE(1'b0)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .hs(hs), .vs(vs), .blank(blank),
    .DrawX(DrawX), .DrawY(DrawY), .line_start(line_start),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  vga_timing_gen dfl (
    .vga_clk(vga_clk), .reset(reset), .hs(d_hs), .vs(d_vs), .blank(d_blank),
    .DrawX(d_DrawX), .DrawY(d_DrawY), .line_start(d_line_start),
    .frame_start(d_frame_start), .frame_count(d_frame_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge vga_clk);
    #1;
  endtask

  initial begin
    int n_blank, n_hs, n_vs, n_ls, n_fs, max_x, max_y, bad_blank;
    int hs_fall_x, hs_rise_x, vs_fall_x, vs_fall_y;
    logic prev_hs, prev_vs;

    // Reset held
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    chk("rst DrawX", DrawX, 0);
    chk("rst DrawY", DrawY, 0);
    chk("rst blank", blank, 0);
    chk("rst hs", hs, 1);
    chk("rst vs", vs, 1);
    chk("rst line_start", line_start, 0);
    chk("rst frame_start", frame_start, 0);
    chk("rst frame_count", frame_count, 0);
    chk("rst dfl hs", d_hs, 1);
    chk("rst dfl vs", d_vs, 1);

    // First edge after release
    reset = 1'b0;
    step(1);
    chk("first DrawX", DrawX, 0);
    chk("first DrawY", DrawY, 0);
    chk("first blank", blank, 1);
    chk("first line_start", line_start, 1);
    chk("first frame_start", frame_start, 1);
    chk("first frame_count", frame_count, 1);
    chk("first dfl frame_start", d_frame_start, 1);
    chk("first dfl blank", d_blank, 1);
    chk("first dfl DrawY", d_DrawY, 0);
    chk("first dfl frame_count", d_frame_count, 1);

    // One full small frame (208 clocks) starting at cycle 0
    n_blank = 0; n_hs = 0; n_vs = 0; n_ls = 0; n_fs = 0; max_x = 0; max_y = 0; bad_blank = 0;
    hs_fall_x = -1; hs_rise_x = -1; vs_fall_x = -1; vs_fall_y = -1;
    prev_hs = 1'b1; prev_vs = 1'b1;
    for (int i = 0; i < 208; i++) begin
      if (blank) n_blank++;
      if (!hs) n_hs++;
      if (!vs) n_vs++;
      if (line_start) n_ls++;
      if (frame_start) n_fs++;
      if (int'(DrawX) > max_x) max_x = int'(DrawX);
      if (int'(DrawY) > max_y) max_y = int'(DrawY);
      if (blank && DrawY >= 10'd6) bad_blank++;
      if (!hs && prev_hs && hs_fall_x < 0) hs_fall_x = int'(DrawX);
      if (hs && !prev_hs && hs_rise_x < 0) hs_rise_x = int'(DrawX);
      if (!vs && prev_vs && vs_fall_y < 0) begin
        vs_fall_x = int'(DrawX);
        vs_fall_y = int'(DrawY);
      end
      prev_hs = hs;
      prev_vs = vs;
      step(1);
    end
    chk("frame blank count", n_blank, 48);
    chk("frame hs low count", n_hs, 39);
    chk("frame vs low count", n_vs, 32);
    chk("frame line_start count", n_ls, 13);
    chk("frame frame_start count", n_fs, 1);
    chk("frame max DrawX", max_x, 15);
    chk("frame max DrawY", max_y, 12);
    chk("blank on lines >= 6", bad_blank, 0);
    chk("hs first low X", hs_fall_x, 10);
    chk("hs high again X", hs_rise_x, 13);
    chk("vs first low X", vs_fall_x, 0);
    chk("vs first low Y", vs_fall_y, 8);
    chk("frame2 frame_start", frame_start, 1);
    chk("frame2 frame_count", frame_count, 2);
    chk("frame2 DrawX", DrawX, 0);
    chk("frame2 DrawY", DrawY, 0);

    // Line wrap mid-frame: (15,3) -> (0,4)
    step(63);
    chk("pre line wrap DrawX", DrawX, 15);
    chk("pre line wrap DrawY", DrawY, 3);
    step(1);
    chk("line wrap DrawX", DrawX, 0);
    chk("line wrap DrawY", DrawY, 4);
    chk("line wrap line_start", line_start, 1);
    chk("line wrap frame_start", frame_start, 0);

    // Frame wrap: (15,12) -> (0,0)
    step(143);
    chk("pre frame wrap DrawX", DrawX, 15);
    chk("pre frame wrap DrawY", DrawY, 12);
    step(1);
    chk("frame wrap DrawX", DrawX, 0);
    chk("frame wrap DrawY", DrawY, 0);
    chk("frame wrap frame_start", frame_start, 1);
    chk("frame3 frame_count", frame_count, 3);

    // Async reset with both syncs active at (11,9)
    step(155);
    chk("pre reset DrawX", DrawX, 11);
    chk("pre reset DrawY", DrawY, 9);
    chk("pre reset hs active", hs, 0);
    chk("pre reset vs active", vs, 0);
    #2 reset = 1'b1;
    #1;
    chk("async rst hs", hs, 1);
    chk("async rst vs", vs, 1);
    chk("async rst DrawX", DrawX, 0);
    chk("async rst DrawY", DrawY, 0);
    chk("async rst blank", blank, 0);
    chk("async rst frame_count", frame_count, 0);
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    reset = 1'b0;
    step(1);
    chk("restart frame_start", frame_start, 1);
    chk("restart DrawX", DrawX, 0);
    chk("restart blank", blank, 1);
    chk("restart frame_count", frame_count, 1);

    // Default timing, one 800-clock line
    n_blank = 0; n_hs = 0; n_ls = 0; hs_fall_x = -1; hs_rise_x = -1; prev_hs = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (d_blank) n_blank++;
      if (!d_hs) n_hs++;
      if (d_line_start) n_ls++;
      if (!d_hs && prev_hs && hs_fall_x < 0) hs_fall_x = int'(d_DrawX);
      if (d_hs && !prev_hs && hs_rise_x < 0) hs_rise_x = int'(d_DrawX);
      prev_hs = d_hs;
      step(1);
    end
    chk("dfl line blank count", n_blank, 640);
    chk("dfl line hs low count", n_hs, 96);
    chk("dfl line_start count", n_ls, 1);
    chk("dfl hs first low X", hs_fall_x, 656);
    chk("dfl hs high again X", hs_rise_x, 752);
    chk("dfl next line DrawX", d_DrawX, 0);
    chk("dfl next line DrawY", d_DrawY, 1);
    chk("dfl next line line_start", d_line_start, 1);
    chk("dfl next line frame_start", d_frame_start, 0);
    chk("dfl vs idle", d_vs, 1);

    // Small instance now at cycle 176 of its frame; deposit 65535 before the next frame_start
    step(31);
    chk("pre deposit DrawX", DrawX, 15);
    chk("pre deposit DrawY", DrawY, 12);
    force dut.frame_count_q = 16'hFFFF;
    #1;
    release dut.frame_count_q;
    #1;
    chk("deposited frame_count", frame_count, 65535);
    step(1);
    chk("wrap frame_start", frame_start, 1);
    chk("wrap frame_count", frame_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
